// File: rtl/uart_rx_engine.sv
// ---------------------------------------------------------------------------
// uart_rx_engine
//
// Purpose: asynchronous-serial receiver. Detects a start bit on RX, samples
// each following bit at its centre using a programmable bit period, checks
// optional parity and the stop bit, then presents the byte with status to a
// host that acknowledges it with a one-cycle read pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active low
//   read        in   one-cycle pulse: host consumed UART_RDATA / RX_STATUS
//   RX          in   serial line, idle high, already synchronised
//   max[18:0]   in   clocks per bit period (>= 16)
//   EIGHT       in   1 = 8 data bits, 0 = 7 data bits
//   PEN         in   1 = parity bit present
//   OHEL        in   1 = odd parity, 0 = even parity
//   RXRDY       out  received byte pending
//   RX_STATUS   out  {OVF, FERR, PERR}
//   UART_RDATA  out  received byte (bit 7 is 0 in 7-bit mode)
//
// Build option:
//   RX_FALSE_START_EN  when defined, a high level at the start-bit centre
//                      is treated as a glitch and the frame is dropped.
// ---------------------------------------------------------------------------
module uart_rx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        RX,
  input  logic [18:0] max,
  input  logic        EIGHT,
  input  logic        PEN,
  input  logic        OHEL,
  output logic        RXRDY,
  output logic [2:0]  RX_STATUS,
  output logic [7:0]  UART_RDATA
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  r_state;
  logic [18:0] r_cnt;
  logic [18:0] r_max;
  logic        r_eight;
  logic        r_pen;
  logic        r_ohel;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_par;
  logic        r_perr;
  logic        r_ferr;
  logic        r_fin;
  logic        r_rxrdy;
  logic [2:0]  r_status;
  logic [7:0]  r_rdata;

  logic [18:0] w_limit;
  logic        w_sample;
  logic [2:0]  w_last_bit;
  logic [7:0]  w_data;
  logic        w_ovf;

  // The start bit is sampled half a period in; every later sample is one
  // full period after the previous one.
  assign w_limit    = (r_state == S_START) ? ((r_max >> 1) - 19'd1)
                                           : (r_max - 19'd1);
  assign w_sample   = (r_cnt == w_limit);
  assign w_last_bit = r_eight ? 3'd7 : 3'd6;
  // Bits arrive LSB first and are shifted in from the top, so a 7-bit
  // frame ends up in [7:1] and needs realigning.
  assign w_data     = r_eight ? r_shift : {1'b0, r_shift[7:1]};
  // A pending byte that the host is not reading right now gets overrun.
  assign w_ovf      = r_rxrdy & ~read;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_max    <= '0;
      r_eight  <= 1'b0;
      r_pen    <= 1'b0;
      r_ohel   <= 1'b0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_fin    <= 1'b0;
      r_rxrdy  <= 1'b0;
      r_status <= '0;
      r_rdata  <= '0;
    end else begin
      r_fin <= 1'b0;

      if (r_state == S_IDLE) begin
        if (!RX) begin
          // Frame configuration is frozen here for the whole frame.
          r_state <= S_START;
          r_cnt   <= '0;
          r_max   <= max;
          r_eight <= EIGHT;
          r_pen   <= PEN;
          r_ohel  <= OHEL;
          r_shift <= '0;
          r_bit   <= '0;
          r_par   <= 1'b0;
          r_perr  <= 1'b0;
          r_ferr  <= 1'b0;
        end
      end else if (!w_sample) begin
        r_cnt <= r_cnt + 19'd1;
      end else begin
        r_cnt <= '0;
        case (r_state)
          S_START: begin
`ifdef RX_FALSE_START_EN
            r_state <= RX ? S_IDLE : S_DATA;
`else
            r_state <= S_DATA;
`endif
          end
          S_DATA: begin
            r_shift <= {RX, r_shift[7:1]};
            r_par   <= r_par ^ RX;
            if (r_bit == w_last_bit) begin
              r_bit   <= '0;
              r_state <= r_pen ? S_PARITY : S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
          S_PARITY: begin
            r_perr  <= ((r_par ^ RX) != r_ohel);
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_ferr  <= ~RX;
            r_fin   <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // Host side: a completing frame takes priority over a read in the
      // same cycle, so the new byte is never lost.
      if (r_fin) begin
        r_rxrdy  <= 1'b1;
        r_rdata  <= w_data;
        r_status <= {w_ovf, r_ferr, r_perr};
      end else if (read && r_rxrdy) begin
        r_rxrdy  <= 1'b0;
        r_status <= '0;
      end
    end
  end

  assign RXRDY      = r_rxrdy;
  assign RX_STATUS  = r_status;
  assign UART_RDATA = r_rdata;

endmodule

// File: tb/tb_uart_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_engine
//
// Directed bench for uart_rx_engine. Frames are driven bit by bit on RX with
// the bit period taken from max; expected bytes and status words are written
// out by hand next to each frame. Build with +define+RX_FALSE_START_EN to
// exercise the glitch-rejecting variant.
// ---------------------------------------------------------------------------
module tb_uart_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        RX;
  logic [18:0] max;
  logic        EIGHT;
  logic        PEN;
  logic        OHEL;
  logic        RXRDY;
  logic [2:0]  RX_STATUS;
  logic [7:0]  UART_RDATA;

  int n_checks = 0;
  int n_errors = 0;
  int rise_idx;

  always #5 clk = ~clk;

  uart_rx_engine dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .RX         (RX),
    .max        (max),
    .EIGHT      (EIGHT),
    .PEN        (PEN),
    .OHEL       (OHEL),
    .RXRDY      (RXRDY),
    .RX_STATUS  (RX_STATUS),
    .UART_RDATA (UART_RDATA)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  // Drives one frame. During the stop bit, loop index i is the number of
  // rising edges since the first stop-bit edge; the stop sample happens at
  // i = max/2 and the outputs appear one edge later. RX returns high right
  // after the stop sample so a low stop bit cannot start a phantom frame.
  // rise_idx records the index at which RXRDY first went 0 -> 1.
  task automatic send_frame(input logic [7:0] data, input int nbits,
                            input bit has_par, input bit par_bit,
                            input bit stop_bit, input bit read_at_done,
                            input bit scramble);
    int   bc;
    logic prev;
    bc       = int'(max);
    rise_idx = -1;
    @(negedge clk);
    RX = 1'b0;
    repeat (bc) @(negedge clk);
    if (scramble) begin
      max   = 19'd16;
      EIGHT = ~EIGHT;
      PEN   = ~PEN;
      OHEL  = ~OHEL;
    end
    for (int b = 0; b < nbits; b++) begin
      RX = data[b];
      repeat (bc) @(negedge clk);
    end
    if (has_par) begin
      RX = par_bit;
      repeat (bc) @(negedge clk);
    end
    RX   = stop_bit;
    prev = RXRDY;
    for (int i = 0; i < bc; i++) begin
      @(negedge clk);
      if (RXRDY && !prev && rise_idx < 0) rise_idx = i;
      prev = RXRDY;
      if (i == bc / 2) begin
        RX = 1'b1;
        if (read_at_done) read = 1'b1;
      end
      if (i == bc / 2 + 1) read = 1'b0;
    end
    idle(2);
  endtask

  task automatic set_cfg(input logic [18:0] m, input logic e, input logic p,
                         input logic o);
    max   = m;
    EIGHT = e;
    PEN   = p;
    OHEL  = o;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] frame;

    rst  = 1'b0;
    read = 1'b0;
    RX   = 1'b1;
    set_cfg(19'd16, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("reset_rxrdy",  RXRDY,      1'b0);
    check("reset_status", RX_STATUS,  3'b000);
    check("reset_rdata",  UART_RDATA, 8'h00);
    rst = 1'b1;
    idle(3);

    // 8N1 0xA5: stop sample 8+16*9 edges after the start edge, outputs one
    // edge later, i.e. stop-bit index 9.
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("a5_latency", rise_idx,   9);
    check("a5_rxrdy",   RXRDY,      1'b1);
    check("a5_rdata",   UART_RDATA, 8'hA5);
    check("a5_status",  RX_STATUS,  3'b000);
    pulse_read();
    check("a5_rd_rxrdy", RXRDY, 1'b0);

    // 7O1 0x41: the seven data bits hold two ones, so odd parity needs a
    // parity bit of 1 (no error) and a parity bit of 0 is an error.
    set_cfg(19'd16, 1'b0, 1'b1, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("p1_rdata",  UART_RDATA, 8'h41);
    check("p1_status", RX_STATUS,  3'b000);
    pulse_read();
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p0_rdata",  UART_RDATA, 8'h41);
    check("p0_status", RX_STATUS,  3'b001);
    pulse_read();

    // 7-bit mode forces bit 7 low even though the line carries 0xC3.
    send_frame(8'hC3, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("c3_7bit_rdata",  UART_RDATA, 8'h43);
    check("c3_7bit_status", RX_STATUS,  3'b000);
    pulse_read();

    // Framing error, then a read clears flags but keeps the byte.
    set_cfg(19'd16, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_rdata",  UART_RDATA, 8'h3C);
    check("ferr_status", RX_STATUS,  3'b010);
    check("ferr_rxrdy",  RXRDY,      1'b1);
    pulse_read();
    check("ferr_rd_rxrdy",  RXRDY,      1'b0);
    check("ferr_rd_status", RX_STATUS,  3'b000);
    check("ferr_rd_rdata",  UART_RDATA, 8'h3C);
    pulse_read();
    check("idle_rd_rxrdy", RXRDY,      1'b0);
    check("idle_rd_rdata", UART_RDATA, 8'h3C);

    // Overrun: two frames without a read.
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovf_rdata",  UART_RDATA, 8'h22);
    check("ovf_status", RX_STATUS,  3'b100);
    check("ovf_rxrdy",  RXRDY,      1'b1);
    pulse_read();

    // Read landing on the completion edge of 0x22: completion wins, no OVF.
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("coinc_rdata",  UART_RDATA, 8'h22);
    check("coinc_status", RX_STATUS,  3'b000);
    check("coinc_rxrdy",  RXRDY,      1'b1);
    pulse_read();

    // max = 20, 8E1, 0x96 (four ones -> even parity bit 0). Inputs are
    // changed right after the start bit and must be ignored for this frame.
    set_cfg(19'd20, 1'b1, 1'b1, 1'b0);
    send_frame(8'h96, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("m20_latency", rise_idx,   11);
    check("m20_rdata",   UART_RDATA, 8'h96);
    check("m20_status",  RX_STATUS,  3'b000);
    pulse_read();

    // Short low glitch on the line.
    set_cfg(19'd16, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    RX = 1'b0;
    repeat (3) @(negedge clk);
    RX = 1'b1;
    idle(200);
`ifdef RX_FALSE_START_EN
    check("glitch_rxrdy", RXRDY,      1'b0);
    check("glitch_rdata", UART_RDATA, 8'h96);
`else
    check("glitch_rxrdy",  RXRDY,      1'b1);
    check("glitch_rdata",  UART_RDATA, 8'hFF);
    check("glitch_status", RX_STATUS,  3'b000);
    pulse_read();
`endif

    // Reset in the middle of data bit 4 of 0x5A.
    frame = 8'h5A;
    @(negedge clk);
    RX = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      RX = frame[b];
      repeat (16) @(negedge clk);
    end
    RX = frame[4];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rxrdy",  RXRDY,      1'b0);
    check("midrst_rdata",  UART_RDATA, 8'h00);
    check("midrst_status", RX_STATUS,  3'b000);
    RX  = 1'b1;
    rst = 1'b1;
    idle(200);
    check("midrst_no_frame", RXRDY, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("after_rst_latency", rise_idx,   9);
    check("after_rst_rdata",   UART_RDATA, 8'h81);
    check("after_rst_status",  RX_STATUS,  3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
